// File: rtl/seq_detect_scheduler.sv
// Round-robin shared serial pattern detector: one stream is granted per cycle and
// its saved shift history / fill level is swapped into a single compare datapath.
module seq_detect_scheduler #(
  parameter int NCH = 4,
  parameter int PLEN = 3,
  parameter logic [PLEN-1:0] PATTERN = 3'b101,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [NCH-1:0]         in_valid,
  input  logic [NCH-1:0]         in_bit,
  output logic [NCH-1:0]         in_ready,
  input  logic                   cnt_clr,
  output logic                   match_valid,
  output logic [$clog2(NCH)-1:0] match_ch,
  output logic [NCH*CNT_W-1:0]   match_count
);

  localparam int CH_W = $clog2(NCH);
  localparam int HW = PLEN - 1;
  localparam int FILL_W = $clog2(PLEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PLEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [HW-1:0]     hist_q [NCH];
  logic [HW-1:0]     hist_d [NCH];
  logic [FILL_W-1:0] fill_q [NCH];
  logic [FILL_W-1:0] fill_d [NCH];
  logic [CNT_W-1:0]  cnt_q  [NCH];
  logic [CNT_W-1:0]  cnt_d  [NCH];
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic              match_valid_q, match_valid_d;
  logic [CH_W-1:0]   match_ch_q, match_ch_d;

  logic [CH_W-1:0] gnt_ch;
  logic            found;
  logic            xfer;
  logic [NCH-1:0]  grant;
  logic [PLEN-1:0] window;
  logic            hit;
  int              idx;

  // Search starts at ptr and wraps; the first requesting channel wins.
  always_comb begin
    gnt_ch = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NCH; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NCH) idx = idx - NCH;
      if (!found && in_valid[idx]) begin
        found  = 1'b1;
        gnt_ch = CH_W'(idx);
      end
    end
    xfer  = found & enable;
    grant = xfer ? (NCH'(1) << gnt_ch) : '0;
  end

  assign in_ready = grant & {NCH{~rst}};

  assign window = {hist_q[gnt_ch], in_bit[gnt_ch]};
  assign hit    = xfer && (fill_q[gnt_ch] == FILL_MAX) && (window == PATTERN);

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      hist_d[k] = hist_q[k];
      fill_d[k] = fill_q[k];
      cnt_d[k]  = cnt_q[k];
    end
    ptr_d         = ptr_q;
    match_valid_d = hit;
    match_ch_d    = match_ch_q;

    if (xfer) begin
      hist_d[gnt_ch] = window[HW-1:0];
      if (fill_q[gnt_ch] < FILL_MAX) fill_d[gnt_ch] = fill_q[gnt_ch] + 1'b1;
      ptr_d      = (gnt_ch == CH_W'(NCH - 1)) ? '0 : gnt_ch + 1'b1;
      match_ch_d = gnt_ch;
    end

    // Clear beats a same-cycle hit; the match pulse itself is unaffected.
    for (int k = 0; k < NCH; k++) begin
      if (cnt_clr) begin
        cnt_d[k] = '0;
      end else if (hit && (gnt_ch == CH_W'(k)) && (cnt_q[k] != CNT_MAX)) begin
        cnt_d[k] = cnt_q[k] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin
        hist_q[k] <= '0;
        fill_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
      ptr_q         <= '0;
      match_valid_q <= 1'b0;
      match_ch_q    <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        hist_q[k] <= hist_d[k];
        fill_q[k] <= fill_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
      ptr_q         <= ptr_d;
      match_valid_q <= match_valid_d;
      match_ch_q    <= match_ch_d;
    end
  end

  assign match_valid = match_valid_q;
  assign match_ch    = match_ch_q;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_cnt_out
    assign match_count[gi*CNT_W +: CNT_W] = cnt_q[gi];
  end

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Directed bench for seq_detect_scheduler: three instances cover the default pattern,
// a 001 pattern (fill guard) and a 2-bit counter (saturation).
module tb_seq_detect_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b1;

  logic [3:0]  a_valid = '0, a_bit = '0, a_ready;
  logic        a_clr = 1'b0, a_mv;
  logic [1:0]  a_ch;
  logic [31:0] a_cnt;

  logic [3:0]  b_valid = '0, b_bit = '0, b_ready;
  logic        b_clr = 1'b0, b_mv;
  logic [1:0]  b_ch;
  logic [31:0] b_cnt;

  logic [3:0]  c_valid = '0, c_bit = '0, c_ready;
  logic        c_clr = 1'b0, c_mv;
  logic [1:0]  c_ch;
  logic [7:0]  c_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_detect_scheduler #(.NCH(4), .PLEN(3), .PATTERN(3'b101), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(a_valid), .in_bit(a_bit),
    .in_ready(a_ready), .cnt_clr(a_clr), .match_valid(a_mv), .match_ch(a_ch),
    .match_count(a_cnt));

  seq_detect_scheduler #(.NCH(4), .PLEN(3), .PATTERN(3'b001), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(b_valid), .in_bit(b_bit),
    .in_ready(b_ready), .cnt_clr(b_clr), .match_valid(b_mv), .match_ch(b_ch),
    .match_count(b_cnt));

  seq_detect_scheduler #(.NCH(4), .PLEN(3), .PATTERN(3'b101), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(c_valid), .in_bit(c_bit),
    .in_ready(c_ready), .cnt_clr(c_clr), .match_valid(c_mv), .match_ch(c_ch),
    .match_count(c_cnt));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_valid = '0; b_valid = '0; c_valid = '0;
    a_clr = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    a_valid = 4'hF;
    a_bit = 4'hF;
    #3;
    n_cmp++;
    if (a_ready !== 4'b0000) begin
      n_err++; $display("FAIL reset_ready: got %b want 0000", a_ready);
    end
    n_cmp++;
    if (a_mv !== 1'b0 || a_ch !== 2'd0) begin
      n_err++; $display("FAIL reset_match: got mv=%b ch=%0d want mv=0 ch=0", a_mv, a_ch);
    end
    n_cmp++;
    if (a_cnt !== 32'd0) begin
      n_err++; $display("FAIL reset_cnt: got %h want 0", a_cnt);
    end
    $display("test_reset done");
    do_reset();
  endtask

  task automatic test_ch0_basic();
    bit [0:4] s = 5'b10101;
    logic exp_mv;
    a_valid = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      a_bit = {3'b000, s[i]};
      #2;
      n_cmp++;
      if (a_ready !== 4'b0001) begin
        n_err++; $display("FAIL t1_ready[%0d]: got %b want 0001", i, a_ready);
      end
      cyc();
      exp_mv = (i == 2) || (i == 4);
      n_cmp++;
      if (a_mv !== exp_mv || (exp_mv && a_ch !== 2'd0)) begin
        n_err++; $display("FAIL t1_match[%0d]: got mv=%b ch=%0d want mv=%b ch=0", i, a_mv, a_ch, exp_mv);
      end
      $display("t1 bit %0d=%b mv=%b ch=%0d", i, s[i], a_mv, a_ch);
    end
    a_valid = '0;
    cyc();
    n_cmp++;
    if (a_mv !== 1'b0) begin
      n_err++; $display("FAIL t1_idle_mv: got %b want 0", a_mv);
    end
    n_cmp++;
    if (a_cnt !== 32'h0000_0002) begin
      n_err++; $display("FAIL t1_count: got %h want 00000002", a_cnt);
    end
  endtask

  task automatic test_round_robin();
    bit [0:2] p = 3'b101;
    logic [3:0] exp_rdy;
    logic exp_mv;
    do_reset();
    a_valid = 4'hF;
    for (int c = 0; c < 12; c++) begin
      a_bit = 4'hF;
      a_bit[2] = p[c / 4];
      exp_rdy = 4'b0001 << (c % 4);
      #2;
      n_cmp++;
      if (a_ready !== exp_rdy) begin
        n_err++; $display("FAIL t3_grant[%0d]: got %b want %b", c, a_ready, exp_rdy);
      end
      cyc();
      exp_mv = (c == 10);
      n_cmp++;
      if (a_mv !== exp_mv || (exp_mv && a_ch !== 2'd2)) begin
        n_err++; $display("FAIL t3_match[%0d]: got mv=%b ch=%0d want mv=%b ch=2", c, a_mv, a_ch, exp_mv);
      end
      $display("t3 cyc %0d grant=%b mv=%b", c, exp_rdy, a_mv);
    end
    a_valid = '0;
    n_cmp++;
    if (a_cnt !== 32'h0001_0000) begin
      n_err++; $display("FAIL t3_counts: got %h want 00010000", a_cnt);
    end
  endtask

  task automatic test_clr_hit();
    bit [0:4] s = 5'b10101;
    do_reset();
    a_valid = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      a_bit = {3'b000, s[i]};
      a_clr = (i == 4);
      if (i == 3) begin
        n_cmp++;
        if (a_cnt[7:0] !== 8'd1) begin
          n_err++; $display("FAIL t5_pre_count: got %0d want 1", a_cnt[7:0]);
        end
      end
      cyc();
      $display("t5 bit %0d=%b clr=%b mv=%b", i, s[i], a_clr, a_mv);
    end
    a_clr = 1'b0;
    a_valid = '0;
    n_cmp++;
    if (a_mv !== 1'b1 || a_ch !== 2'd0) begin
      n_err++; $display("FAIL t5_mv: got mv=%b ch=%0d want mv=1 ch=0", a_mv, a_ch);
    end
    n_cmp++;
    if (a_cnt !== 32'd0) begin
      n_err++; $display("FAIL t5_count: got %h want 0", a_cnt);
    end
  endtask

  task automatic test_enable();
    a_valid = 4'b0001;
    a_bit = 4'b0001; cyc();
    a_bit = 4'b0000; cyc();
    enable = 1'b0;
    a_valid = 4'hF;
    a_bit = 4'hF;
    for (int i = 0; i < 2; i++) begin
      #2;
      n_cmp++;
      if (a_ready !== 4'b0000) begin
        n_err++; $display("FAIL en_ready[%0d]: got %b want 0000", i, a_ready);
      end
      cyc();
      n_cmp++;
      if (a_mv !== 1'b0 || a_cnt !== 32'd0) begin
        n_err++; $display("FAIL en_hold[%0d]: got mv=%b cnt=%h want mv=0 cnt=0", i, a_mv, a_cnt);
      end
      $display("en_off cyc %0d ready=%b mv=%b", i, a_ready, a_mv);
    end
    enable = 1'b1;
    #2;
    n_cmp++;
    if (a_ready !== 4'b0010) begin
      n_err++; $display("FAIL en_ptr_held: got %b want 0010", a_ready);
    end
    a_valid = 4'b0001;
    a_bit = 4'b0001;
    cyc();
    a_valid = '0;
    n_cmp++;
    if (a_mv !== 1'b1 || a_ch !== 2'd0 || a_cnt !== 32'd1) begin
      n_err++; $display("FAIL en_ctx_held: got mv=%b ch=%0d cnt=%h want mv=1 ch=0 cnt=1", a_mv, a_ch, a_cnt);
    end
    $display("en_on resume mv=%b cnt=%h", a_mv, a_cnt);
  endtask

  task automatic test_reset_midstream();
    bit [0:2] s = 3'b101;
    logic exp_mv;
    a_valid = 4'b0001;
    a_bit = 4'b0001; cyc();
    a_bit = 4'b0000; cyc();
    rst = 1'b1;
    a_valid = 4'hF;
    #2;
    n_cmp++;
    if (a_ready !== 4'b0000) begin
      n_err++; $display("FAIL t6_ready_in_rst: got %b want 0000", a_ready);
    end
    n_cmp++;
    if (a_cnt !== 32'd0 || a_mv !== 1'b0) begin
      n_err++; $display("FAIL t6_rst_state: got cnt=%h mv=%b want 0/0", a_cnt, a_mv);
    end
    cyc();
    rst = 1'b0;
    a_valid = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      a_bit = {3'b000, s[i]};
      cyc();
      exp_mv = (i == 2);
      n_cmp++;
      if (a_mv !== exp_mv) begin
        n_err++; $display("FAIL t6_match[%0d]: got %b want %b", i, a_mv, exp_mv);
      end
      $display("t6 bit %0d=%b mv=%b", i, s[i], a_mv);
    end
    a_valid = '0;
  endtask

  task automatic test_fill_guard();
    bit [0:3] s = 4'b1001;
    logic exp_mv;
    do_reset();
    b_valid = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      b_bit = {2'b00, s[i], 1'b0};
      cyc();
      exp_mv = (i == 3);
      n_cmp++;
      if (b_mv !== exp_mv || (exp_mv && b_ch !== 2'd1)) begin
        n_err++; $display("FAIL t2_match[%0d]: got mv=%b ch=%0d want mv=%b ch=1", i, b_mv, b_ch, exp_mv);
      end
      $display("t2 bit %0d=%b mv=%b", i, s[i], b_mv);
    end
    b_valid = '0;
    n_cmp++;
    if (b_cnt !== 32'h0000_0100) begin
      n_err++; $display("FAIL t2_count: got %h want 00000100", b_cnt);
    end
  endtask

  task automatic test_saturation();
    int pulses = 0;
    int hits = 0;
    logic exp_mv;
    logic [1:0] exp_cnt;
    do_reset();
    c_valid = 4'b1000;
    for (int i = 0; i < 11; i++) begin
      c_bit = {(i % 2 == 0), 3'b000};
      cyc();
      exp_mv = (i >= 2) && (i % 2 == 0);
      if (exp_mv) hits++;
      if (c_mv === 1'b1) pulses++;
      exp_cnt = (hits > 3) ? 2'd3 : 2'(hits);
      n_cmp++;
      if (c_mv !== exp_mv || c_cnt[7:6] !== exp_cnt) begin
        n_err++; $display("FAIL t4_step[%0d]: got mv=%b cnt=%0d want mv=%b cnt=%0d", i, c_mv, c_cnt[7:6], exp_mv, exp_cnt);
      end
      $display("t4 bit %0d mv=%b cnt3=%0d", i, c_mv, c_cnt[7:6]);
    end
    c_valid = '0;
    n_cmp++;
    if (pulses != 5) begin
      n_err++; $display("FAIL t4_pulses: got %0d want 5", pulses);
    end
    n_cmp++;
    if (c_cnt !== 8'hC0) begin
      n_err++; $display("FAIL t4_final: got %h want c0", c_cnt);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ch0_basic();
    test_round_robin();
    test_clr_hit();
    test_enable();
    test_reset_midstream();
    test_fill_guard();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
